mem_rr_arbiter: RTL

//  Round-robin arbiter sharing one req/gnt/rvalid memory slave port among N masters
//  (core data port, debug unit, SPI-slave loader) in front of a single RAM bank.

---
 rtl/mem_rr_arbiter_if.sv | 48 ++++
 rtl/mem_rr_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mem_rr_arbiter_if.sv
// Bus bundle between the requesting masters, the round-robin arbiter and the RAM slave port.
// The master modport is the arbiter's view; the slave modport is the surrounding system.
interface mem_rr_arbiter_if #(
    parameter int N_MASTERS  = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int SEL_WIDTH = $clog2(N_MASTERS);

    logic [N_MASTERS-1:0]            m_req_i;
    logic [N_MASTERS-1:0]            m_gnt_o;
    logic [N_MASTERS*ADDR_WIDTH-1:0] m_addr_i;
    logic [N_MASTERS-1:0]            m_we_i;
    logic [N_MASTERS*BE_WIDTH-1:0]   m_be_i;
    logic [N_MASTERS*DATA_WIDTH-1:0] m_wdata_i;
    logic [N_MASTERS-1:0]            m_rvalid_o;
    logic [DATA_WIDTH-1:0]           m_rdata_o;

    logic                            s_req_o;
    logic                            s_gnt_i;
    logic [ADDR_WIDTH-1:0]           s_addr_o;
    logic                            s_we_o;
    logic [BE_WIDTH-1:0]             s_be_o;
    logic [DATA_WIDTH-1:0]           s_wdata_o;
    logic                            s_rvalid_i;
    logic [DATA_WIDTH-1:0]           s_rdata_i;

    logic                            err_o;
    logic [SEL_WIDTH-1:0]            cnt_sel_i;
    logic [15:0]                     cnt_o;

    modport master (
        input  m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
        input  s_gnt_i, s_rvalid_i, s_rdata_i, cnt_sel_i,
        output m_gnt_o, m_rvalid_o, m_rdata_o,
        output s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o,
        output err_o, cnt_o
    );

    modport slave (
        output m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
        output s_gnt_i, s_rvalid_i, s_rdata_i, cnt_sel_i,
        input  m_gnt_o, m_rvalid_o, m_rdata_o,
        input  s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o,
        input  err_o, cnt_o
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid RAM port among N masters, with an in-order
// ID FIFO routing responses back. Optional per-master grant counters: MEM_ARB_PERF_CNT_EN.
module mem_rr_arbiter #(
    parameter int N_MASTERS       = 3,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_rr_arbiter_if.master  bus
);
    localparam int BW = DATA_WIDTH / 8;
    localparam int IW = $clog2(N_MASTERS);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [IW-1:0] ptr_reg, ptr_next;
    logic          hold_vld_reg, hold_vld_next;
    logic [IW-1:0] hold_id_reg, hold_id_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          err_reg, err_next;
    logic [IW-1:0] fifo_mem [MAX_OUTSTANDING];

    logic [IW-1:0] scan_sel;
    logic [IW:0]   scan_idx;
    logic [IW-1:0] sel;
    logic [IW-1:0] head;
    logic          full;
    logic          s_req;
    logic          push;
    logic          pop;

    // First requester at or after ptr wins; scanning downward lets the nearest overwrite.
    always_comb begin
        scan_sel = ptr_reg;
        scan_idx = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            scan_idx = {1'b0, ptr_reg} + (IW+1)'(i);
            if (scan_idx >= (IW+1)'(N_MASTERS))
                scan_idx = scan_idx - (IW+1)'(N_MASTERS);
            if (bus.m_req_i[scan_idx[IW-1:0]])
                scan_sel = scan_idx[IW-1:0];
        end
    end

    assign sel   = hold_vld_reg ? hold_id_reg : scan_sel;
    assign full  = (count_reg == CW'(MAX_OUTSTANDING));
    assign s_req = !rst && bus.m_req_i[sel] && !full;
    assign push  = s_req && bus.s_gnt_i;
    assign pop   = !rst && bus.s_rvalid_i && (count_reg != '0);
    assign head  = fifo_mem[rd_ptr_reg];

    assign bus.s_req_o    = s_req;
    assign bus.s_addr_o   = s_req ? bus.m_addr_i[sel*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign bus.s_we_o     = s_req ? bus.m_we_i[sel] : 1'b0;
    assign bus.s_be_o     = s_req ? bus.m_be_i[sel*BW +: BW] : '0;
    assign bus.s_wdata_o  = s_req ? bus.m_wdata_i[sel*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.m_gnt_o    = push ? (N_MASTERS'(1) << sel) : '0;
    assign bus.m_rvalid_o = pop ? (N_MASTERS'(1) << head) : '0;
    assign bus.m_rdata_o  = pop ? bus.s_rdata_i : '0;
    assign bus.err_o      = err_reg;

    always_comb begin
        ptr_next      = ptr_reg;
        hold_vld_next = hold_vld_reg;
        hold_id_next  = hold_id_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg + CW'(push) - CW'(pop);
        err_next      = err_reg | (bus.s_rvalid_i && (count_reg == '0));
        if (push) begin
            ptr_next      = (sel == IW'(N_MASTERS - 1)) ? '0 : sel + 1'b1;
            hold_vld_next = 1'b0;
            wr_ptr_next   = (wr_ptr_reg == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_reg + 1'b1;
        end else if (s_req) begin
            hold_vld_next = 1'b1;
            hold_id_next  = sel;
        end else if (hold_vld_reg && !bus.m_req_i[hold_id_reg]) begin
            // Held master withdrew its request: release so arbitration resumes.
            hold_vld_next = 1'b0;
        end
        if (pop)
            rd_ptr_next = (rd_ptr_reg == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_reg + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg      <= '0;
            hold_vld_reg <= 1'b0;
            hold_id_reg  <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            err_reg      <= 1'b0;
        end else begin
            ptr_reg      <= ptr_next;
            hold_vld_reg <= hold_vld_next;
            hold_id_reg  <= hold_id_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            err_reg      <= err_next;
        end
    end

    // ID storage is only ever read behind count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= sel;
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [N_MASTERS*16-1:0] cnt_vec;

    generate
        for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_cnt
            logic [15:0] cnt_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    cnt_reg <= 16'h0000;
                else if (bus.m_gnt_o[gi] && (cnt_reg != 16'hFFFF))
                    cnt_reg <= cnt_reg + 16'h0001;
            end
            assign cnt_vec[gi*16 +: 16] = cnt_reg;
        end
    endgenerate

    assign bus.cnt_o = (!rst && ({1'b0, bus.cnt_sel_i} < (IW+1)'(N_MASTERS)))
                       ? cnt_vec[{bus.cnt_sel_i, 4'b0000} +: 16] : 16'h0000;
`else
    logic unused_cnt_sel;
    assign unused_cnt_sel = ^bus.cnt_sel_i;
    assign bus.cnt_o      = 16'h0000;
`endif
endmodule
